// File: rtl/goldminer_pkg.sv
// goldminer_pkg: game-state encodings, object ranges, sprite sizes, speeds and scores
// shared by the hook collider and the gold-position block.
package goldminer_pkg;
    typedef enum logic [1:0] {GS_WAVE = 2'b00, GS_STRETCH = 2'b01, GS_HIT = 2'b10, GS_MISS = 2'b11} game_state_e;
    typedef enum logic [2:0] {IDLE, SEEK, HOLD, MISS, COLLECT} hook_state_e;
    localparam logic [10:0] H_ACTIVE = 11'd1440;
    localparam logic [9:0] V_ACTIVE = 10'd900;
    localparam logic [3:0] NO_OBJ = 4'hF;
    localparam int N_OBJ = 10;
    localparam int GOLD_LAST = 4;
    localparam int DIAM_LAST = 6;
    localparam int GOLD_SZ = 60;
    localparam int DIAM_SZ = 40;
    localparam int STONE_SZ = 80;
    localparam logic [2:0] SPD_EMPTY = 3'd6;
    localparam logic [2:0] SPD_GOLD = 3'd2;
    localparam logic [2:0] SPD_DIAM = 3'd4;
    localparam logic [2:0] SPD_STONE = 3'd1;
    localparam logic [15:0] SCORE_GOLD = 16'd100;
    localparam logic [15:0] SCORE_DIAM = 16'd500;
    localparam logic [15:0] SCORE_STONE = 16'd20;

    function automatic int obj_sz(input int i);
        return i <= GOLD_LAST ? GOLD_SZ : i <= DIAM_LAST ? DIAM_SZ : STONE_SZ;
    endfunction

    function automatic logic [2:0] obj_spd(input logic [3:0] idx);
        return int'(idx) <= GOLD_LAST ? SPD_GOLD : int'(idx) <= DIAM_LAST ? SPD_DIAM : SPD_STONE;
    endfunction

    function automatic logic [15:0] obj_score(input logic [3:0] idx);
        return int'(idx) <= GOLD_LAST ? SCORE_GOLD : int'(idx) <= DIAM_LAST ? SCORE_DIAM : SCORE_STONE;
    endfunction
endpackage

// File: rtl/hook_collider_if.sv
// hook_collider_if: gold-interaction bus between game side (master) and hook collider (slave).
interface hook_collider_if;
    logic [1:0] state;
    logic [10:0] hook_x;
    logic [9:0] hook_y;
    logic [109:0] obj_x;
    logic [99:0] obj_y;
    logic [3:0] hitted_gold;
    logic [10:0] blk_x;
    logic [9:0] blk_y;
    logic hit_req;
    logic miss_req;
    logic [2:0] retract_spd;
    logic [15:0] score;
    modport master (output state, hook_x, hook_y, obj_x, obj_y,
                    input hitted_gold, blk_x, blk_y, hit_req, miss_req, retract_spd, score);
    modport slave (input state, hook_x, hook_y, obj_x, obj_y,
                   output hitted_gold, blk_x, blk_y, hit_req, miss_req, retract_spd, score);
endinterface

// File: rtl/obj_hit_cmp.sv
// obj_hit_cmp: combinational live/touch test of the hook tip against one SZ x SZ sprite.
module obj_hit_cmp
    import goldminer_pkg::*;
#(
    parameter int SZ = 60
) (
    input  logic [10:0] obj_x_i,
    input  logic [9:0]  obj_y_i,
    input  logic [10:0] hook_x_i,
    input  logic [9:0]  hook_y_i,
    output logic        touch_o
);
    logic [11:0] x_end;
    logic [10:0] y_end;
    // One extra bit so sprites near the coordinate ceiling never wrap.
    assign x_end = {1'b0, obj_x_i} + 12'(SZ - 1);
    assign y_end = {1'b0, obj_y_i} + 11'(SZ - 1);
    assign touch_o = obj_x_i < H_ACTIVE && obj_y_i < V_ACTIVE
                  && hook_x_i >= obj_x_i && {1'b0, hook_x_i} <= x_end
                  && hook_y_i >= obj_y_i && {1'b0, hook_y_i} <= y_end;
endmodule

// File: rtl/hook_collider.sv
// hook_collider: detects the object under the hook tip, holds it and reports hit/miss/speed.
// Optional HOOK_SCORE_EN: accumulate a saturating score on each collected object.
module hook_collider
    import goldminer_pkg::*;
(
    input  logic            pixclk_60,
    input  logic            rst,
    hook_collider_if.slave  bus_io
);
    logic [N_OBJ-1:0] touch;
    logic [3:0] idx;
    hook_state_e st_q, st_d;
    logic [3:0] hg_q, hg_d;
    logic [10:0] bx_q, bx_d;
    logic [9:0] by_q, by_d;
    logic hit_q, hit_d, miss_q, miss_d;
    logic [2:0] spd_q, spd_d;
    logic [10:0] half_sel, half_hold;
    logic oob;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_cmp
        obj_hit_cmp #(.SZ(obj_sz(g))) u_cmp (
            .obj_x_i (bus_io.obj_x[g*11 +: 11]),
            .obj_y_i (bus_io.obj_y[g*10 +: 10]),
            .hook_x_i(bus_io.hook_x),
            .hook_y_i(bus_io.hook_y),
            .touch_o (touch[g])
        );
    end

    always_comb begin
        idx = NO_OBJ;
        for (int i = N_OBJ - 1; i >= 0; i--) if (touch[i]) idx = 4'(i);
    end

    assign half_sel = 11'(obj_sz(int'(idx)) / 2);
    assign half_hold = 11'(obj_sz(int'(hg_q)) / 2);
    assign oob = bus_io.hook_x >= H_ACTIVE || bus_io.hook_y >= V_ACTIVE || bus_io.hook_x == 11'd0;

    always_comb begin
        st_d = st_q;
        hg_d = hg_q;
        bx_d = bx_q;
        by_d = by_q;
        hit_d = 1'b0;
        miss_d = 1'b0;
        spd_d = spd_q;
        unique case (st_q)
            IDLE: begin
                hg_d = NO_OBJ;
                spd_d = SPD_EMPTY;
                if (bus_io.state == GS_STRETCH) st_d = SEEK;
            end
            SEEK: begin
                // A catch takes precedence over leaving the play area.
                if (|touch) begin
                    st_d = HOLD;
                    hg_d = idx;
                    hit_d = 1'b1;
                    spd_d = obj_spd(idx);
                    bx_d = bus_io.hook_x >= half_sel ? bus_io.hook_x - half_sel : 11'd0;
                    by_d = bus_io.hook_y;
                end else if (oob) begin
                    st_d = MISS;
                    miss_d = 1'b1;
                    spd_d = SPD_EMPTY;
                end else if (bus_io.state == GS_WAVE) st_d = IDLE;
            end
            HOLD: begin
                bx_d = bus_io.hook_x >= half_hold ? bus_io.hook_x - half_hold : 11'd0;
                by_d = bus_io.hook_y;
                if (bus_io.state == GS_WAVE) st_d = COLLECT;
            end
            MISS: begin
                spd_d = SPD_EMPTY;
                if (bus_io.state == GS_WAVE) st_d = IDLE;
            end
            COLLECT: begin
                hg_d = NO_OBJ;
                spd_d = SPD_EMPTY;
                st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge pixclk_60) begin
        if (rst) begin
            st_q <= IDLE;
            hg_q <= NO_OBJ;
            bx_q <= 11'd0;
            by_q <= 10'd0;
            hit_q <= 1'b0;
            miss_q <= 1'b0;
            spd_q <= SPD_EMPTY;
        end else begin
            st_q <= st_d;
            hg_q <= hg_d;
            bx_q <= bx_d;
            by_q <= by_d;
            hit_q <= hit_d;
            miss_q <= miss_d;
            spd_q <= spd_d;
        end
    end

    assign bus_io.hitted_gold = hg_q;
    assign bus_io.blk_x = bx_q;
    assign bus_io.blk_y = by_q;
    assign bus_io.hit_req = hit_q;
    assign bus_io.miss_req = miss_q;
    assign bus_io.retract_spd = spd_q;

`ifdef HOOK_SCORE_EN
    logic [15:0] score_q;
    logic [16:0] score_sum;
    assign score_sum = {1'b0, score_q} + {1'b0, obj_score(hg_q)};
    always_ff @(posedge pixclk_60) begin
        if (rst) score_q <= 16'd0;
        else if (st_q == COLLECT) score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
    assign bus_io.score = score_q;
`else
    assign bus_io.score = 16'd0;
`endif
endmodule

// File: tb/tb_hook_collider.sv
// tb_hook_collider: directed and randomized checks of hook_collider against a behavioural model.
module tb_hook_collider;
    localparam int M_IDLE = 0, M_SEEK = 1, M_HOLD = 2, M_MISS = 3, M_COLLECT = 4;
    logic pixclk_60 = 1'b0;
    logic rst;
    always #5 pixclk_60 = ~pixclk_60;

    hook_collider_if bus();
    hook_collider dut (.pixclk_60(pixclk_60), .rst(rst), .bus_io(bus.slave));

    int checks = 0, errors = 0;
    int ox[10], oy[10];
    int hx, hy, gst;
    int m_mode, m_hg, m_bx, m_by, m_hit, m_miss, m_spd, m_score;

    function automatic int sz_of(input int i);
        return i < 5 ? 60 : (i < 7 ? 40 : 80);
    endfunction
    function automatic int spd_of(input int i);
        return i < 5 ? 2 : (i < 7 ? 4 : 1);
    endfunction
    function automatic int pts_of(input int i);
        return i < 5 ? 100 : (i < 7 ? 500 : 20);
    endfunction
    function automatic bit touched(input int i);
        return ox[i] < 1440 && oy[i] < 900 && hx >= ox[i] && hx <= ox[i] + sz_of(i) - 1
            && hy >= oy[i] && hy <= oy[i] + sz_of(i) - 1;
    endfunction
    function automatic int sat0(input int v);
        return v < 0 ? 0 : v;
    endfunction

    task automatic model_step();
        int first;
        m_hit = 0;
        m_miss = 0;
        if (rst) begin
            m_mode = M_IDLE; m_hg = 15; m_bx = 0; m_by = 0; m_spd = 6; m_score = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_hg = 15; m_spd = 6;
                if (gst == 1) m_mode = M_SEEK;
            end
            M_SEEK: begin
                first = -1;
                for (int i = 9; i >= 0; i--) if (touched(i)) first = i;
                if (first >= 0) begin
                    m_mode = M_HOLD; m_hg = first; m_hit = 1; m_spd = spd_of(first);
                    m_bx = sat0(hx - sz_of(first) / 2); m_by = hy;
                end else if (hx >= 1440 || hy >= 900 || hx == 0) begin
                    m_mode = M_MISS; m_miss = 1; m_spd = 6;
                end else if (gst == 0) m_mode = M_IDLE;
            end
            M_HOLD: begin
                m_bx = sat0(hx - sz_of(m_hg) / 2); m_by = hy;
                if (gst == 0) m_mode = M_COLLECT;
            end
            M_MISS: begin
                m_spd = 6;
                if (gst == 0) m_mode = M_IDLE;
            end
            default: begin
`ifdef HOOK_SCORE_EN
                m_score = m_score + pts_of(m_hg) > 65535 ? 65535 : m_score + pts_of(m_hg);
`endif
                m_hg = 15; m_spd = 6; m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic check_all();
        chk("hitted_gold", 32'(bus.hitted_gold), 32'(m_hg));
        chk("blk_x", 32'(bus.blk_x), 32'(m_bx));
        chk("blk_y", 32'(bus.blk_y), 32'(m_by));
        chk("hit_req", 32'(bus.hit_req), 32'(m_hit));
        chk("miss_req", 32'(bus.miss_req), 32'(m_miss));
        chk("retract_spd", 32'(bus.retract_spd), 32'(m_spd));
        chk("score", 32'(bus.score), 32'(m_score));
    endtask

    task automatic cycle();
        bus.state = 2'(gst);
        bus.hook_x = 11'(hx);
        bus.hook_y = 10'(hy);
        for (int i = 0; i < 10; i++) begin
            bus.obj_x[i*11 +: 11] = 11'(ox[i]);
            bus.obj_y[i*10 +: 10] = 10'(oy[i]);
        end
        @(posedge pixclk_60);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clear_objs();
        for (int i = 0; i < 10; i++) begin ox[i] = 2000; oy[i] = 900; end
    endtask

    task automatic catch_collect(input int i, input int x, input int y);
        clear_objs();
        ox[i] = x; oy[i] = y; hx = x + 5; hy = y + 5;
        gst = 1; cycle(); cycle();
        gst = 0; cycle(); cycle();
    endtask

    initial begin
        rst = 1'b1; gst = 0; hx = 700; hy = 400;
        clear_objs();
        cycle(); cycle();
        chk("rst_hg", 32'(bus.hitted_gold), 32'hF);
        chk("rst_spd", 32'(bus.retract_spd), 32'd6);
        rst = 1'b0;
        // basic gold catch
        ox[0] = 100; oy[0] = 200; hx = 120; hy = 230; gst = 1;
        cycle(); cycle();
        chk("t1_hit", 32'(bus.hit_req), 32'd1);
        chk("t1_hg", 32'(bus.hitted_gold), 32'd0);
        chk("t1_spd", 32'(bus.retract_spd), 32'd2);
        chk("t1_bx", 32'(bus.blk_x), 32'd90);
        hx = 125; hy = 180; gst = 2; cycle(); cycle();
        chk("t1_hold", 32'(bus.hitted_gold), 32'd0);
        gst = 0; cycle(); cycle();
        chk("t1_done", 32'(bus.hitted_gold), 32'hF);
        // overlapping diamond and stone: lower index wins
        clear_objs();
        ox[5] = 300; oy[5] = 300; ox[7] = 290; oy[7] = 290; hx = 310; hy = 310; gst = 1;
        cycle(); cycle();
        chk("t2_hg", 32'(bus.hitted_gold), 32'd5);
        chk("t2_spd", 32'(bus.retract_spd), 32'd4);
        gst = 0; cycle(); cycle();
        // removed object, hook off-screen
        clear_objs();
        hx = 2010; hy = 905; gst = 1;
        cycle(); cycle();
        chk("t3_miss", 32'(bus.miss_req), 32'd1);
        chk("t3_hg", 32'(bus.hitted_gold), 32'hF);
        cycle();
        gst = 0; cycle();
        // stone collect then score saturation on diamonds
        catch_collect(8, 500, 500);
        for (int k = 0; k < 135; k++) catch_collect(5, 600, 100);
`ifdef HOOK_SCORE_EN
        chk("t4_sat", 32'(bus.score), 32'hFFFF);
`endif
        // hook at x=0 on object: catch beats miss, blk_x clamps
        clear_objs();
        ox[0] = 0; oy[0] = 0; hx = 0; hy = 10; gst = 1;
        cycle(); cycle();
        chk("t5_hit", 32'(bus.hit_req), 32'd1);
        chk("t5_miss", 32'(bus.miss_req), 32'd0);
        chk("t5_bx", 32'(bus.blk_x), 32'd0);
        // reset while holding
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("t6_hg", 32'(bus.hitted_gold), 32'hF);
        chk("t6_spd", 32'(bus.retract_spd), 32'd6);
        gst = 0; cycle();
        // randomized play
        for (int n = 0; n < 600; n++) begin
            if (n % 40 == 0)
                for (int i = 0; i < 10; i++) begin
                    ox[i] = ($urandom_range(0, 7) == 0) ? 2000 : int'($urandom_range(0, 1400));
                    oy[i] = ($urandom_range(0, 7) == 0) ? 900 : int'($urandom_range(0, 850));
                end
            begin
                int j;
                j = int'($urandom_range(0, 9));
                hx = ox[j] + int'($urandom_range(0, 100)) - 10;
                hy = oy[j] + int'($urandom_range(0, 100)) - 10;
                if (hx < 0) hx = 0;
                if (hx > 2047) hx = 2047;
                if (hy < 0) hy = 0;
                if (hy > 1023) hy = 1023;
                if ($urandom_range(0, 15) == 0) hx = ($urandom_range(0, 1) == 0) ? 0 : 1500;
            end
            gst = int'($urandom_range(0, 3));
            rst = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
